// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding and default tuning-word width for the DDS sweep block
package dds_pkg;
  localparam int DDS_PHASE_W = 32;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear tuning-word sweep sequencer feeding the DDS FreqWord/ClkEn inputs
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [PHASE_W-1:0] start_word,
  input  logic [PHASE_W-1:0] stop_word,
  input  logic [PHASE_W-1:0] step_word,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [PHASE_W-1:0] freq_word,
  output logic               clk_en,
  output logic               busy,
  output logic               done
);
  state_t             state;
  logic [PHASE_W-1:0] start_w, stop_w, step_w;
  logic [DWELL_W-1:0] dwell_m1, cnt;
  logic               cont;
  logic [PHASE_W:0]   sum;
  logic [PHASE_W-1:0] nxt;
  logic [DWELL_W-1:0] dwell_in_m1;
  logic               at_end;
  // carry out of the wide sum clamps to the stop word instead of wrapping
  assign sum         = {1'b0, freq_word} + {1'b0, step_w};
  assign nxt         = (step_w == '0 || sum >= {1'b0, stop_w}) ? stop_w : sum[PHASE_W-1:0];
  assign at_end      = freq_word >= stop_w;
  assign dwell_in_m1 = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_W'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      freq_word <= '0;
      clk_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      start_w   <= '0;
      stop_w    <= '0;
      step_w    <= '0;
      dwell_m1  <= '0;
      cont      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        freq_word <= '0;
        clk_en    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            start_w   <= start_word;
            stop_w    <= stop_word;
            step_w    <= step_word;
            dwell_m1  <= dwell_in_m1;
            cont      <= continuous;
            freq_word <= start_word;
            clk_en    <= 1'b1;
            busy      <= 1'b1;
            cnt       <= dwell_in_m1;
            state     <= DWELL;
          end
          DWELL: if (cnt != '0) begin
            cnt <= cnt - DWELL_W'(1);
          end else if (!at_end) begin
            freq_word <= nxt;
            cnt       <= dwell_m1;
          end else if (cont) begin
            freq_word <= start_w;
            cnt       <= dwell_m1;
          end else begin
            state     <= DONE;
            freq_word <= '0;
            clk_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed table-driven bench for the DDS sweep sequencer
module tb_dds_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [31:0] start_word = '0, stop_word = '0, step_word = '0;
  logic [15:0] dwell_cycles = '0;
  logic [31:0] freq_word;
  logic        clk_en, busy, done;
  int          n_chk = 0, n_fail = 0;

  typedef struct packed {
    logic [31:0]      sw, pw, stw;
    logic [15:0]      dw;
    logic [3:0][31:0] pts;
    int               n, d;
  } sweep_t;

  sweep_t tbl [5];

  dds_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .start_word(start_word), .stop_word(stop_word), .step_word(step_word),
    .dwell_cycles(dwell_cycles), .freq_word(freq_word), .clk_en(clk_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic sweep_t mk(logic [31:0] sw, pw, stw, logic [15:0] dw,
                                logic [31:0] p0, p1, p2, p3, int n, int d);
    sweep_t s;
    s.sw = sw; s.pw = pw; s.stw = stw; s.dw = dw;
    s.pts[0] = p0; s.pts[1] = p1; s.pts[2] = p2; s.pts[3] = p3;
    s.n = n; s.d = d;
    return s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [31:0] f, input logic e, b, d);
    chk({nm, ".freq"}, freq_word, f);
    chk({nm, ".clk_en"}, {31'd0, clk_en}, {31'd0, e});
    chk({nm, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({nm, ".done"}, {31'd0, done}, {31'd0, d});
  endtask

  task automatic run_sweep(input sweep_t s, input bit poke, input string nm);
    start_word = s.sw; stop_word = s.pw; step_word = s.stw;
    dwell_cycles = s.dw; continuous = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    start_word = 32'hDEAD_BEEF; stop_word = 32'h0; step_word = 32'd7;
    dwell_cycles = 16'd9; continuous = 1'b1;
    for (int p = 0; p < s.n; p++)
      for (int c = 0; c < s.d; c++) begin
        chk_out(nm, s.pts[p], 1'b1, 1'b1, 1'b0);
        if (poke && p == 1 && c == 0) start = 1'b1;
        tick;
        start = 1'b0;
      end
    chk_out({nm, ".done_cycle"}, 32'd0, 1'b0, 1'b0, 1'b1);
    tick;
    chk_out({nm, ".after"}, 32'd0, 1'b0, 1'b0, 1'b0);
    continuous = 1'b0;
  endtask

  initial begin
    tbl[0] = mk(32'd100, 32'd130, 32'd10, 16'd3, 32'd100, 32'd110, 32'd120, 32'd130, 4, 3);
    tbl[1] = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1,
                32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0, 2, 1);
    tbl[2] = mk(32'd1, 32'd3, 32'd1, 16'd0, 32'd1, 32'd2, 32'd3, 32'd0, 3, 1);
    tbl[3] = mk(32'd80, 32'd50, 32'd1, 16'd2, 32'd80, 32'd0, 32'd0, 32'd0, 1, 2);
    tbl[4] = mk(32'd10, 32'd90, 32'd0, 16'd1, 32'd10, 32'd90, 32'd0, 32'd0, 2, 1);

    #2;
    chk_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk_out("idle", 32'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) run_sweep(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    run_sweep(tbl[0], 1'b1, "ignore_start");

    // continuous 5..7, then abort during the second visit of 6
    start_word = 32'd5; stop_word = 32'd7; step_word = 32'd1;
    dwell_cycles = 16'd2; continuous = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    begin
      logic [31:0] seq [9];
      seq = '{32'd5, 32'd5, 32'd6, 32'd6, 32'd7, 32'd7, 32'd5, 32'd5, 32'd6};
      for (int k = 0; k < 9; k++) begin
        chk_out($sformatf("cont%0d", k), seq[k], 1'b1, 1'b1, 1'b0);
        tick;
      end
    end
    chk_out("cont_pre_abort", 32'd6, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk_out("abort", 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    chk_out("abort_idle", 32'd0, 1'b0, 1'b0, 1'b0);
    continuous = 1'b0;

    start_word = 32'd100; stop_word = 32'd130; step_word = 32'd10; dwell_cycles = 16'd3;
    start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    chk_out("start_stop_prio", 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    chk_out("start_stop_prio2", 32'd0, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    chk_out("pre_reset", 32'd100, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_out($sformatf("post_reset%0d", k), 32'd0, 1'b0, 1'b0, 1'b0);
    end
    run_sweep(tbl[4], 1'b0, "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
